// File: rtl/mp_adder_seq_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding and the fixed adder word width.
package mp_adder_seq_pkg;

    localparam int ADDER_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/binary_adder_32_bit.sv
// Plain 32-bit ripple adder owned by the parent.
// The sequencer borrows it one word per cycle.
module binary_adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    // full-width sum with carry in and carry out
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/mp_adder_seq.sv
// WORDS x 32-bit add/subtract driven through one external adder,
// least significant word first, carry chained through a register.
module mp_adder_seq
    import mp_adder_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int W     = ADDER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic [WORDS*W-1:0] op_a,
    input  logic [WORDS*W-1:0] op_b,
    output logic               busy,
    output logic               done,
    output logic [WORDS*W-1:0] result,
    output logic               carry_out,
    output logic               overflow,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_cin,
    input  logic [W-1:0]       add_s,
    input  logic               add_cout
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]             idx;
    logic [WORDS-1:0][W-1:0]   a_q;
    logic [WORDS-1:0][W-1:0]   b_q;
    logic [WORDS-1:0][W-1:0]   res_q;
    logic                      sub_q;
    logic                      carry_q;
    logic                      done_q;
    logic                      cout_q;
    logic                      ovf_q;
    logic                      last;
    logic                      accept;
    logic                      msb_cin;

    assign last    = (idx == IW'(WORDS - 1));
    assign accept  = (state == IDLE) && start;
    assign msb_cin = add_a[W-1] ^ add_b[W-1] ^ add_s[W-1];

    assign busy      = (state == RUN);
    assign done      = done_q;
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state: leave IDLE on start, return after the top word
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // word-select mux onto the shared adder; idle drives zeros
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[idx];
            add_b   = b_q[idx];
            add_cin = (idx == '0) ? sub_q : carry_q;
        end
    end

    // operand capture; subtraction stores ~B so the adder sees A+~B+1
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            sub_q <= sub;
        end
    end

    // word index, carry chain, result words and final flags
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                idx <= '0;
            end else if (state == RUN) begin
                res_q[idx] <= add_s;
                carry_q    <= add_cout;
                idx        <= idx + 1'b1;
                if (last) begin
                    idx    <= '0;
                    done_q <= 1'b1;
                    cout_q <= add_cout;
                    ovf_q  <= add_cout ^ msb_cin;
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq with the parent's 32-bit adder.
// Table vectors, randomized ops against a wide-arithmetic model, corner sequences.
module tb_mp_adder_seq;

    localparam int WORDS = 4;
    localparam int W     = 32;
    localparam int WW    = WORDS * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic [WW-1:0] op_a;
    logic [WW-1:0] op_b;
    logic          busy;
    logic          done;
    logic [WW-1:0] result;
    logic          carry_out;
    logic          overflow;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_s;
    logic          add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp_adder_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    binary_adder_32_bit u_add (
        .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout)
    );

    typedef struct {
        string         name;
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic          s;
        logic [WW-1:0] r;
        logic          c;
        logic          v;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // full-width reference: result, carry and signed overflow
    function automatic logic [WW+1:0] model(input logic [WW-1:0] a,
                                            input logic [WW-1:0] b,
                                            input logic s);
        logic [WW-1:0] bb;
        logic [WW:0]   sum;
        logic          v;
        bb  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{WW{1'b0}}, s};
        v   = (a[WW-1] == bb[WW-1]) && (sum[WW-1] != a[WW-1]);
        return {v, sum};
    endfunction

    function automatic logic [WW-1:0] rnd128();
        logic [WW-1:0] x;
        for (int i = 0; i < WORDS; i++) x[i*W +: W] = $urandom;
        return x;
    endfunction

    task automatic start_op(input logic [WW-1:0] a, input logic [WW-1:0] b,
                            input logic s);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
    endtask

    // called at a negedge right after start_op
    task automatic wait_done(input string nm, input logic [WW-1:0] er,
                             input logic ec, input logic ev);
        int cyc = 0;
        int nb  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) nb++;
        end while (!done && cyc < 40);
        chk({nm, " latency"}, WW'(cyc), WW'(WORDS + 1));
        chk({nm, " busy_cycles"}, WW'(nb), WW'(WORDS));
        chk({nm, " result"}, result, er);
        chk({nm, " carry_out"}, WW'(carry_out), WW'(ec));
        chk({nm, " overflow"}, WW'(overflow), WW'(ev));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [WW-1:0] ones;
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic [WW+1:0] m;
        logic          s;
        logic [WW-1:0] cap;
        int            nd;
        int            dc;

        ones = '1;
        vt[0] = '{"add_aa55", {WORDS{32'hAAAAAAAA}}, {WORDS{32'h55555555}},
                  1'b0, ones, 1'b0, 1'b0};
        vt[1] = '{"add_wordcarry", WW'(32'hFFFFFFFF), WW'(1), 1'b0,
                  WW'(64'h1_0000_0000), 1'b0, 1'b0};
        vt[2] = '{"add_wrap", ones, WW'(1), 1'b0, '0, 1'b1, 1'b0};
        vt[3] = '{"add_ovf", {1'b0, {(WW-1){1'b1}}}, WW'(1), 1'b0,
                  {1'b1, {(WW-1){1'b0}}}, 1'b0, 1'b1};
        vt[4] = '{"sub_borrow", '0, WW'(1), 1'b1, ones, 1'b0, 1'b0};
        vt[5] = '{"sub_5m3", WW'(5), WW'(3), 1'b1, WW'(2), 1'b1, 1'b0};
        vt[6] = '{"sub_ovf", {1'b1, {(WW-1){1'b0}}}, WW'(1), 1'b1,
                  {1'b0, {(WW-1){1'b1}}}, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", WW'(busy), '0);
        chk("rst done", WW'(done), '0);
        chk("rst result", result, '0);
        chk("rst carry_out", WW'(carry_out), '0);
        chk("rst overflow", WW'(overflow), '0);
        chk("idle add_a", WW'(add_a), '0);
        chk("idle add_cin", WW'(add_cin), '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start_op(vt[i].a, vt[i].b, vt[i].s);
            wait_done(vt[i].name, vt[i].r, vt[i].c, vt[i].v);
            repeat (i % 2) @(negedge clk);
        end

        for (int i = 0; i < 30; i++) begin
            a = rnd128();
            b = rnd128();
            s = 1'(($urandom >> 3) & 1);
            if (i % 5 == 1) b = '0;
            if (i % 7 == 2) a = {WORDS{32'hFFFFFFFF}};
            m = model(a, b, s);
            start_op(a, b, s);
            wait_done($sformatf("rand%0d", i), m[WW-1:0], m[WW], m[WW+1]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // start pulsed mid-run must be ignored
        m = model(WW'(100), WW'(23), 1'b0);
        start_op(WW'(100), WW'(23), 1'b0);
        nd  = 0;
        dc  = 0;
        cap = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 2) start_op(ones, ones, 1'b1);
            if (done) begin
                nd++;
                dc  = i;
                cap = result;
            end
        end
        chk("midrun done_count", WW'(nd), WW'(1));
        chk("midrun done_cycle", WW'(dc), WW'(WORDS + 1));
        chk("midrun result", cap, m[WW-1:0]);
        chk("midrun idle_after", WW'(busy), '0);

        // start in the done cycle is accepted back-to-back
        m = model(WW'(7), WW'(8), 1'b0);
        start_op(WW'(7), WW'(8), 1'b0);
        wait_done("b2b_first", m[WW-1:0], m[WW], m[WW+1]);
        a = rnd128();
        b = rnd128();
        m = model(a, b, 1'b1);
        start_op(a, b, 1'b1);
        wait_done("b2b_second", m[WW-1:0], m[WW], m[WW+1]);

        // reset mid-run
        start_op(WW'(5), WW'(3), 1'b1);
        wait_done("pre_rst", WW'(2), 1'b1, 1'b0);
        start_op(ones, WW'(1), 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", WW'(busy), '0);
        chk("midrst done", WW'(done), '0);
        chk("midrst result", result, '0);
        chk("midrst carry_out", WW'(carry_out), '0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst no_done", WW'(nd), '0);
        m = model(WW'(64'hFFFF_FFFF_FFFF_FFFF), WW'(1), 1'b0);
        start_op(WW'(64'hFFFF_FFFF_FFFF_FFFF), WW'(1), 1'b0);
        wait_done("post_rst", m[WW-1:0], m[WW], m[WW+1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
